// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter/mux.
package rr_arbiter_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Bit 'pos' of the one-hot code for index 'idx'.
    function automatic logic onehot_bit(input int idx, input int pos);
        return (idx == pos);
    endfunction

endpackage

// File: rtl/rr_arbiter_mux_pick.sv
// Combinational winner selection: rotate by the start pointer, take the lowest set bit, un-rotate.
module rr_pick
    import rr_arbiter_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  arb_mode_e        mode,
    output logic             found,
    output logic [IDX_W-1:0] winner
);

    logic [N_CH-1:0]  rot;
    logic [IDX_W-1:0] src;
    int               start;
    int               off;

    always_comb begin
        start  = (mode == ARB_RR) ? int'(ptr) : 0;
        rot    = '0;
        src    = '0;
        found  = 1'b0;
        off    = 0;
        for (int i = 0; i < N_CH; i++) begin
            src    = IDX_W'((i + start) % N_CH);
            rot[i] = req[src];
        end
        // Descending scan so the lowest set position is the last one written.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = i;
            end
        end
        winner = IDX_W'((off + start) % N_CH);
    end

endmodule

// File: rtl/rr_arbiter_mux.sv
// N-channel valid/ready arbiter feeding one registered output carrying data, binary index and one-hot grant.
module rr_arbiter_mux
    import rr_arbiter_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 8,
    localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    input  logic [N_CH-1:0]        req_valid,
    input  logic [N_CH*DATA_W-1:0] req_data,
    output logic [N_CH-1:0]        req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic [N_CH-1:0]        out_onehot
);

    logic [IDX_W-1:0]  ptr;
    logic              found;
    logic [IDX_W-1:0]  winner;
    logic              load_en;
    logic              take;
    logic [N_CH-1:0]   win_onehot;
    logic [DATA_W-1:0] win_data;
    logic [IDX_W-1:0]  ptr_next;

    rr_pick #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .mode   (arb_mode_e'(mode)),
        .found  (found),
        .winner (winner)
    );

    assign load_en  = !out_valid || out_ready;
    assign take     = load_en && found;
    assign ptr_next = IDX_W'((int'(winner) + 1) % N_CH);

    always_comb begin
        win_onehot = '0;
        win_data   = '0;
        for (int i = 0; i < N_CH; i++) begin
            win_onehot[i] = onehot_bit(int'(winner), i);
            if (onehot_bit(int'(winner), i)) begin
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready = take ? win_onehot : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            out_onehot <= '0;
            ptr        <= '0;
        end else if (take) begin
            out_valid  <= 1'b1;
            out_data   <= win_data;
            out_idx    <= winner;
            out_onehot <= win_onehot;
            if (arb_mode_e'(mode) == ARB_RR) begin
                ptr <= ptr_next;
            end
        end else if (out_ready) begin
            // Drained with nothing pending: payload fields keep their last value.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Directed plan plus randomized traffic against a behavioural arbiter model.
module tb_rr_arbiter_mux;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           mode;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_idx;
    logic [N-1:0]   out_onehot;

    rr_arbiter_mux #(.N_CH(N), .DATA_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_onehot (out_onehot)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state
    int       m_ptr;
    logic     m_valid;
    logic [7:0] m_data;
    int       m_idx;
    logic [3:0] m_oh;
    logic [7:0] d [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_pick(input logic [3:0] v, input logic m, input int p);
        int base;
        base = m ? p : 0;
        for (int k = 0; k < N; k++) begin
            if (v[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 1'b0; m_data = '0; m_idx = 0; m_oh = '0;
    endtask

    task automatic drive(input logic m, input logic [3:0] v, input logic ordy);
        mode = m; req_valid = v; out_ready = ordy;
        req_data = {d[3], d[2], d[1], d[0]};
    endtask

    // One clock: check combinational ready, step the model on the edge, check registered outputs.
    task automatic tick(input string tag);
        int w;
        logic le;
        logic [3:0] exp_rr;
        #2;
        le = !m_valid || out_ready;
        w  = ref_pick(req_valid, mode, m_ptr);
        exp_rr = (le && w >= 0) ? 4'(1 << w) : 4'b0000;
        check({tag, ".req_ready"}, 32'(req_ready), 32'(exp_rr));
        @(posedge clk);
        if (le && w >= 0) begin
            m_valid = 1'b1;
            m_data  = d[w];
            m_idx   = w;
            m_oh    = 4'(1 << w);
            if (mode) m_ptr = (w + 1) % N;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check({tag, ".out_valid"},  32'(out_valid),  32'(m_valid));
        check({tag, ".out_data"},   32'(out_data),   32'(m_data));
        check({tag, ".out_idx"},    32'(out_idx),    32'(m_idx));
        check({tag, ".out_onehot"}, 32'(out_onehot), 32'(m_oh));
    endtask

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) d[i] = 8'(8'h11 * (i + 1) - 8'h11 * (i == 0 ? 1 : 0));
        d[0] = 8'h00; d[1] = 8'h11; d[2] = 8'h22; d[3] = 8'h33;
        rst_n = 1'b0;
        drive(1'b0, 4'b0000, 1'b0);
        model_reset();
        #13;
        rst_n = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 5; i++) tick("idle");
        check("idle.ready_const", 32'(req_ready), 32'h0);

        // 2: fixed priority, ch1 always beats ch3
        drive(1'b0, 4'b1010, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick("fixed");
            check("fixed.idx_const", 32'(out_idx), 32'd1);
            check("fixed.data_const", 32'(out_data), 32'h11);
        end

        // 3: round robin over all channels
        drive(1'b1, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick("rr_all");
            check("rr_all.order", 32'(out_idx), 32'(order[i]));
        end

        // 4: backpressure holds the word, release loads next on the same edge
        drive(1'b1, 4'b0110, 1'b1);
        tick("bp_load");
        check("bp_load.idx_const", 32'(out_idx), 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick("bp_hold");
            check("bp_hold.idx_const", 32'(out_idx), 32'd1);
        end
        out_ready = 1'b1;
        tick("bp_release");
        check("bp_release.idx_const", 32'(out_idx), 32'd2);

        // 5: mode switch keeps ptr
        drive(1'b0, 4'b1001, 1'b1);
        tick("sw_fixed");
        check("sw_fixed.idx_const", 32'(out_idx), 32'd0);
        drive(1'b1, 4'b1001, 1'b1);
        tick("sw_rr");
        check("sw_rr.idx_const", 32'(out_idx), 32'd3);

        // 6: asynchronous reset mid-stream
        drive(1'b1, 4'b0100, 1'b1);
        tick("pre_rst");
        check("pre_rst.idx_const", 32'(out_idx), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst.out_valid",  32'(out_valid),  32'h0);
        check("async_rst.out_idx",    32'(out_idx),    32'h0);
        check("async_rst.out_onehot", 32'(out_onehot), 32'h0);
        check("async_rst.out_data",   32'(out_data),   32'h0);
        #3;
        rst_n = 1'b1;
        drive(1'b1, 4'b0101, 1'b1);
        tick("post_rst");
        check("post_rst.idx_const", 32'(out_idx), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) d[i] = 8'($urandom);
            drive(1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 3) != 0));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
